// File: rtl/fc_output_packer.sv
// rtl/fc_output_packer.sv - bias, ReLU, round/saturate and pack FC neuron sums into activation SRAM words
//
// Ports:
//   clk, srstn          clock, asynchronous active-low reset
//   start               one-cycle layer start; latches neuron_num, base_addr, relu_en
//   neuron_num          neurons in the layer (0 completes immediately with no writes)
//   base_addr           first SRAM word address
//   relu_en             clamp negative biased sums to zero
//   mac_valid           data_in/bias valid this cycle (only accepted while running)
//   data_in, bias       finished 32-bit MAC sum and 16-bit bias
//   busy                layer in progress
//   done                one-cycle pulse at end of layer
//   sram_wen            active-low write strobe, one cycle per word
//   sram_waddr          write address, holds between writes
//   sram_wdata          packed activations, lane j in bits [8j+7:8j]
module fc_output_packer #(
    parameter int FRAC_SHIFT = 7,
    parameter int PACK_NUM   = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     start,
    input  logic [9:0]               neuron_num,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     relu_en,
    input  logic                     mac_valid,
    input  logic signed [31:0]       data_in,
    input  logic signed [15:0]       bias,
    output logic                     busy,
    output logic                     done,
    output logic                     sram_wen,
    output logic [ADDR_WIDTH-1:0]    sram_waddr,
    output logic [PACK_NUM*8-1:0]    sram_wdata
);

    localparam int LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int WORD_W = PACK_NUM * 8;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);
    localparam logic signed [33:0] HALF = 34'sd1 <<< (FRAC_SHIFT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [9:0]              n_q;
    logic [9:0]              acc_cnt;
    logic                    relu_q;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [LANE_W-1:0]       lane_cnt;

    // Stage 1: biased (and ReLU-clamped) sum
    logic                    s1_valid;
    logic                    s1_last;
    logic [LANE_W-1:0]       s1_lane;
    logic signed [32:0]      s1_sum;

    // Set in the cycle the final word strobe is on the bus
    logic                    wr_last;
    logic [WORD_W-1:0]       pack_buf;

    logic                    accept;
    logic                    last_accept;
    logic                    done_next;
    logic signed [32:0]      sum_raw;
    logic signed [33:0]      rounded;
    logic signed [33:0]      shifted;
    logic [7:0]              act;
    logic [WORD_W-1:0]       word_next;

    assign busy        = (state != IDLE);
    assign accept      = (state == RUN) && mac_valid;
    assign last_accept = accept && ((acc_cnt + 10'd1) == n_q);
    assign sum_raw     = {data_in[31], data_in} + {{17{bias[15]}}, bias};

    // Round half up, arithmetic shift, saturate to int8
    always_comb begin
        rounded = {s1_sum[32], s1_sum} + HALF;
        shifted = rounded >>> FRAC_SHIFT;
        if (shifted > 34'sd127)
            act = 8'h7F;
        else if (shifted < -34'sd128)
            act = 8'h80;
        else
            act = shifted[7:0];
    end

    always_comb begin
        word_next = pack_buf;
        for (int j = 0; j < PACK_NUM; j++) begin
            if (s1_lane == LANE_W'(j))
                word_next[8*j +: 8] = act;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (neuron_num != 10'd0)
                        state_next = RUN;
                    else
                        done_next = 1'b1;
                end
            end
            RUN: begin
                if (last_accept)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (wr_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            n_q        <= '0;
            acc_cnt    <= '0;
            relu_q     <= 1'b0;
            word_addr  <= '0;
            lane_cnt   <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_lane    <= '0;
            s1_sum     <= '0;
            wr_last    <= 1'b0;
            pack_buf   <= '0;
            done       <= 1'b0;
            sram_wen   <= 1'b1;
            sram_waddr <= '0;
            sram_wdata <= '0;
        end else begin
            done     <= done_next;
            s1_valid <= accept;
            s1_last  <= last_accept;
            wr_last  <= s1_valid && s1_last;
            sram_wen <= 1'b1;

            if (state == IDLE && start) begin
                n_q       <= neuron_num;
                relu_q    <= relu_en;
                word_addr <= base_addr;
                acc_cnt   <= '0;
                lane_cnt  <= '0;
                pack_buf  <= '0;
            end

            if (accept) begin
                s1_sum   <= (relu_q && sum_raw[32]) ? '0 : sum_raw;
                s1_lane  <= lane_cnt;
                acc_cnt  <= acc_cnt + 10'd1;
                lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
            end

            // Word goes out when the top lane fills or on the layer's last neuron
            if (s1_valid) begin
                if (s1_lane == LAST_LANE || s1_last) begin
                    sram_wen   <= 1'b0;
                    sram_waddr <= word_addr;
                    sram_wdata <= word_next;
                    word_addr  <= word_addr + 1'b1;
                    pack_buf   <= '0;
                end else begin
                    pack_buf <= word_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_output_packer.sv
// tb/tb_fc_output_packer.sv - scoreboard bench for fc_output_packer
module tb_fc_output_packer;

    logic               clk = 1'b0;
    logic               srstn = 1'b0;
    logic               start = 1'b0;
    logic [9:0]         neuron_num = '0;
    logic [9:0]         base_addr = '0;
    logic               relu_en = 1'b0;
    logic               mac_valid = 1'b0;
    logic signed [31:0] data_in = '0;
    logic signed [15:0] bias = '0;
    logic               busy;
    logic               done;
    logic               sram_wen;
    logic [9:0]         sram_waddr;
    logic [31:0]        sram_wdata;

    fc_output_packer #(.FRAC_SHIFT(7), .PACK_NUM(4), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .srstn      (srstn),
        .start      (start),
        .neuron_num (neuron_num),
        .base_addr  (base_addr),
        .relu_en    (relu_en),
        .mac_valid  (mac_valid),
        .data_in    (data_in),
        .bias       (bias),
        .busy       (busy),
        .done       (done),
        .sram_wen   (sram_wen),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write is popped against the expected queue
    always @(negedge clk) begin
        if (done === 1'b1)
            done_cnt = done_cnt + 1;
        if (srstn === 1'b1 && sram_wen !== 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write got addr=%h data=%h cyc=%0d exp none", sram_waddr, sram_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (sram_waddr !== e.addr || sram_wdata !== e.data || cyc !== e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL write got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                             sram_waddr, sram_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    function automatic logic [7:0] act_model(input longint d, input longint b, input bit relu);
        longint s;
        longint r;
        s = d + b;
        if (relu && s < 0) s = 0;
        r = (s + 64) >>> 7;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r[7:0];
    endfunction

    task automatic push_exp(input logic [9:0] a, input logic [31:0] d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic start_layer(input int n, input int base, input bit relu);
        @(negedge clk);
        start      = 1'b1;
        neuron_num = n[9:0];
        base_addr  = base[9:0];
        relu_en    = relu;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [31:0] d, input logic signed [15:0] b, output int t);
        @(negedge clk);
        mac_valid = 1'b1;
        data_in   = d;
        bias      = b;
        t         = cyc + 1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            mac_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int max, output bit seen, output int at, output logic busy_at);
        seen = 1'b0;
        at = -1;
        busy_at = 1'bx;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                at = cyc;
                busy_at = busy;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sram_wen !== 1'b1 || sram_waddr !== 10'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b wen=%b waddr=%h wdata=%h exp 0 0 1 0 0",
                     busy, done, sram_wen, sram_waddr, sram_wdata);
        end
        srstn = 1'b1;
    endtask

    task automatic test_full_word;
        logic signed [31:0] v[4];
        int t;
        int at;
        bit seen;
        logic busy_at;
        int d0;
        v[0] = 1000; v[1] = 20000; v[2] = -300; v[3] = -40000;
        d0 = done_cnt;
        start_layer(4, 'h010, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_word_busy got %b exp 1", busy);
        end
        for (int i = 0; i < 4; i++) feed(v[i], 16'sd0, t);
        push_exp(10'h010, 32'h80FE7F08, t + 1);
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL full_word_done_cycle got %0d exp %0d", at, t + 2);
        end
        checks++;
        if (busy_at !== 1'b0) begin
            errors++;
            $display("FAIL full_word_busy_at_done got %b exp 0", busy_at);
        end
        idle(2);
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_word_end got done_cnt=%0d pending=%0d exp 1 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_relu_bias;
        logic signed [31:0] v[4];
        int t;
        int at;
        bit seen;
        logic busy_at;
        v[0] = 1000; v[1] = 20000; v[2] = -300; v[3] = -40000;
        start_layer(4, 'h020, 1'b1);
        for (int i = 0; i < 4; i++) feed(v[i], 16'sd64, t);
        push_exp(10'h020, 32'h00007F08, t + 1);
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL relu_done_cycle got %0d exp %0d", at, t + 2);
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL relu_pending got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_partial_gaps;
        int t;
        int at;
        bit seen;
        logic busy_at;
        int d0;
        d0 = done_cnt;
        start_layer(6, 'h100, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 3));
            feed(32'sd128, 16'sd0, t);
            if (i == 3) push_exp(10'h100, 32'h01010101, t + 1);
            if (i == 5) push_exp(10'h101, 32'h00000101, t + 1);
        end
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL partial_done_cycle got %0d exp %0d", at, t + 2);
        end
        idle(4);
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL partial_end got done_cnt=%0d pending=%0d exp 1 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_zero_and_stray;
        int t;
        int at;
        bit seen;
        logic busy_at;
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) feed(32'sd5000, 16'sd0, t);
        idle(2);
        start_layer(0, 'h055, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b exp 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width got %b exp 0", done);
        end
        start_layer(4, 'h030, 1'b0);
        feed(32'sd128, 16'sd0, t);
        feed(32'sd128, 16'sd0, t);
        start = 1'b1;
        neuron_num = 10'd1;
        base_addr = 10'h200;
        feed(32'sd128, 16'sd0, t);
        start = 1'b0;
        feed(32'sd128, 16'sd0, t);
        push_exp(10'h030, 32'h01010101, t + 1);
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL stray_done_cycle got %0d exp %0d", at, t + 2);
        end
        idle(3);
        checks++;
        if (done_cnt - d0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stray_end got done_cnt=%0d pending=%0d exp 2 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        int t;
        int at;
        bit seen;
        logic busy_at;
        int d;
        int b;
        logic [31:0] word;
        logic [9:0] a;
        word = '0;
        start_layer(8, 'h3FF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(0, 100000)) - 50000;
            b = int'($urandom_range(0, 2000)) - 1000;
            feed(d, b[15:0], t);
            word[8*(i%4) +: 8] = act_model(d, b, 1'b0);
            if (i % 4 == 3) begin
                a = 10'h3FF + 10'(i / 4);
                push_exp(a, word, t + 1);
                word = '0;
            end
        end
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL wrap_done_cycle got %0d exp %0d", at, t + 2);
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_pending got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int t;
        int at;
        bit seen;
        logic busy_at;
        int d0;
        d0 = done_cnt;
        start_layer(8, 'h020, 1'b0);
        for (int i = 0; i < 4; i++) feed(32'sd128, 16'sd0, t);
        push_exp(10'h020, 32'h01010101, t + 1);
        feed(32'sd128, 16'sd0, t);
        @(negedge clk);
        mac_valid = 1'b0;
        #2;
        srstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sram_wen !== 1'b1 || sram_waddr !== 10'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b wen=%b waddr=%h wdata=%h exp 0 0 1 0 0",
                     busy, done, sram_wen, sram_waddr, sram_wdata);
        end
        repeat (3) @(negedge clk);
        srstn = 1'b1;
        idle(10);
        checks++;
        if (done_cnt != d0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_abort got done_cnt=%0d pending=%0d exp 0 0", done_cnt - d0, exp_q.size());
        end
        start_layer(4, 'h040, 1'b0);
        for (int i = 0; i < 4; i++) feed(32'sd128, 16'sd0, t);
        push_exp(10'h040, 32'h01010101, t + 1);
        idle(1);
        wait_done(20, seen, at, busy_at);
        checks++;
        if (!seen || at !== t + 2) begin
            errors++;
            $display("FAIL restart_done_cycle got %0d exp %0d", at, t + 2);
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_pending got %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_full_word;
        test_relu_bias;
        test_partial_gaps;
        test_zero_and_stray;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fc_output_packer.md
# fc_output_packer

Downstream stage of the fully-connected multiplier-accumulator: it takes each finished 32-bit neuron sum, adds a bias, applies optional ReLU, rounds and right-shifts back to 8-bit activation precision with saturation, then packs PACK_NUM activations per word and writes them to the activation SRAM. One layer pass is framed by a `start` pulse and ends with a `done` pulse. The block owns the write address counter and the end-of-layer flush of a partial word.

## Interface
- `FRAC_SHIFT`, 7: arithmetic right-shift amount from accumulator domain to activation domain (≥1).
- `PACK_NUM`, 4: activations per SRAM word.
- `ADDR_WIDTH`, 10: SRAM address width.
- `clk` input 1: single clock; all state on rising edge.
- `srstn` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse; latches `neuron_num`, `base_addr`, `relu_en`.
- `neuron_num` input 10: neurons in this layer (0–1023).
- `base_addr` input ADDR_WIDTH: first write address.
- `relu_en` input 1: clamp negative sums to 0 before shifting.
- `mac_valid` input 1: `data_in`/`bias` valid this cycle.
- `data_in` input signed 32: finished MAC sum.
- `bias` input signed 16: bias for this neuron, sign-extended before addition.
- `busy` output 1: layer in progress.
- `done` output 1: one-cycle pulse, layer complete.
- `sram_wen` output 1: active-low write strobe.
- `sram_waddr` output ADDR_WIDTH: write address.
- `sram_wdata` output PACK_NUM*8: packed activations; lane j in bits [8j+7:8j].

## Operation
- FSM states IDLE, RUN, DRAIN.
  - IDLE: `start` with `neuron_num`≠0 → RUN. With `neuron_num`=0 → stay IDLE, `done` pulses next cycle, no writes.
  - RUN: accept every `mac_valid` cycle. When the accepted count reaches `neuron_num`, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the final write has been issued, then → IDLE with `done`.
- `mac_valid` is ignored outside RUN. `start` is ignored while `busy`.
- Arithmetic per neuron k:
  - s = data_in + sext(bias), computed at 33 bits.
  - If `relu_en` and s<0, s=0.
  - r = (s + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, i.e. round half up.
  - Saturate r to [-128,127] and write it as two's-complement.
- Packing:
  - Neuron k goes to lane k mod PACK_NUM at address `base_addr` + k/PACK_NUM, modulo 2^ADDR_WIDTH (wraps silently).
  - A word is written when lane PACK_NUM-1 is filled or neuron k = `neuron_num`-1.
  - Unused lanes of a partial last word are 0.
  - The pack buffer clears after each write.

## Timing
- Reset values: `busy`=0, `done`=0, `sram_wen`=1, `sram_waddr`=0, `sram_wdata`=0. FSM goes to IDLE; counters and pack buffer clear.
- Reset mid-layer aborts the layer: no `done` and no further writes.
- `busy` rises at the edge that samples `start` and falls at the same edge that raises `done`.
- Pipeline:
  - Input accepted at edge t.
  - Bias/ReLU result registered at edge t.
  - Round, saturate and pack at edge t+1.
  - If that completes a word, `sram_wen`=0 with `sram_waddr`/`sram_wdata` valid for the cycle after edge t+1: latency 2 cycles, strobe exactly 1 cycle wide.
- Back-to-back `mac_valid` sustains one neuron per cycle, so there is one write every PACK_NUM cycles.
- Gaps in `mac_valid` are allowed; no timeout.
- `done` is asserted at edge t+2, where t is the edge accepting the last neuron, i.e. the cycle after the last write strobe.
- `sram_waddr`/`sram_wdata` hold their last values while `sram_wen`=1.

## Test plan
- Full-word rounding and saturation:
  - Stimulus: `neuron_num`=4, `base_addr`=0x010, `relu_en`=0, bias=0, `data_in` = 1000, 20000, -300, -40000 on consecutive cycles.
  - Required: one write to 0x010 with wdata=0x80FE7F08 (8, 127, -2, -128), 2 cycles after the 4th input; `done` the next cycle.
- ReLU and bias:
  - Stimulus: same data with `relu_en`=1, bias=+64 on every neuron.
  - Required: wdata=0x00007F08 (lane0 = (1064+64)>>7 = 8).
- Partial word and gaps:
  - Stimulus: `neuron_num`=6 with random `mac_valid` gaps, all data_in=128.
  - Required: writes {0x01010101 @base, 0x00000101 @base+1}; `done` once.
- Zero-length layer and ignored inputs:
  - Stimulus: `neuron_num`=0; also pulse `mac_valid` in IDLE and `start` while busy.
  - Required: `done` one cycle after `start`, no `sram_wen` pulse; stray inputs produce no writes.
- Address wrap:
  - Stimulus: `base_addr`=0x3FF, `neuron_num`=8.
  - Required: writes at 0x3FF then 0x000.
- Async reset mid-layer:
  - Stimulus: assert `srstn` low between words.
  - Required: outputs immediately at reset values; no `done`; a new `start` after release runs cleanly from the new `base_addr`.
